adc_phase_sampler: RTL and testbench



---
 rtl/adc_phase_sampler.sv | 122 ++++++++++++
 tb/tb_adc_phase_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adc_phase_sampler.sv
// Time-multiplexed RED / IR / DARK LED sequencer with windowed ADC averaging.
// Publishes ambient-subtracted RED and IR averages once per frame with a one-cycle strobe.
module adc_phase_sampler #(
    parameter int unsigned PHASE_CYCLES  = 10,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] DARK_ADC_Value,
    output logic       sample_valid
);
    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned AW = 8 + AVG_LOG2;

    localparam logic [CW-1:0] WinLo   = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] WinHi   = CW'(SETTLE_CYCLES + N - 1);
    localparam logic [CW-1:0] LastCnt = CW'(PHASE_CYCLES - 1);

    if (SETTLE_CYCLES + N > PHASE_CYCLES) begin : g_bad_params
        $error("adc_phase_sampler: SETTLE_CYCLES + 2**AVG_LOG2 exceeds PHASE_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StRed, StIr, StDark} state_e;

    state_e        state;
    logic [CW-1:0] phase_cnt;
    logic [AW-1:0] red_acc, ir_acc, dark_acc;

    logic          in_win;
    logic [AW-1:0] dark_sum;
    logic [7:0]    red_avg, ir_avg, dark_avg;

    // The dark sum includes this edge's sample so a window ending on the last cycle counts.
    always_comb begin
        in_win   = (phase_cnt >= WinLo) && (phase_cnt <= WinHi);
        dark_sum = dark_acc;
        if (state == StDark && in_win) begin
            dark_sum = dark_acc + AW'(ADC);
        end
        red_avg  = 8'(red_acc >> AVG_LOG2);
        ir_avg   = 8'(ir_acc >> AVG_LOG2);
        dark_avg = 8'(dark_sum >> AVG_LOG2);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            phase_cnt      <= '0;
            red_acc        <= '0;
            ir_acc         <= '0;
            dark_acc       <= '0;
            LED_RED        <= 1'b0;
            LED_IR         <= 1'b0;
            RED_ADC_Value  <= '0;
            IR_ADC_Value   <= '0;
            DARK_ADC_Value <= '0;
            sample_valid   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == StIdle || !enable) begin
                // Idle or abort: drop any partial frame, published values hold.
                phase_cnt <= '0;
                red_acc   <= '0;
                ir_acc    <= '0;
                dark_acc  <= '0;
                LED_IR    <= 1'b0;
                if (state == StIdle && enable) begin
                    state   <= StRed;
                    LED_RED <= 1'b1;
                end else begin
                    state   <= StIdle;
                    LED_RED <= 1'b0;
                end
            end else begin
                if (in_win) begin
                    unique case (state)
                        StRed:   red_acc  <= red_acc + AW'(ADC);
                        StIr:    ir_acc   <= ir_acc + AW'(ADC);
                        StDark:  dark_acc <= dark_sum;
                        default: ;
                    endcase
                end
                if (phase_cnt == LastCnt) begin
                    phase_cnt <= '0;
                    unique case (state)
                        StRed: begin
                            state   <= StIr;
                            LED_RED <= 1'b0;
                            LED_IR  <= 1'b1;
                        end
                        StIr: begin
                            state  <= StDark;
                            LED_IR <= 1'b0;
                        end
                        StDark: begin
                            state          <= StRed;
                            LED_RED        <= 1'b1;
                            DARK_ADC_Value <= dark_avg;
                            RED_ADC_Value  <= (red_avg >= dark_avg) ? red_avg - dark_avg : 8'd0;
                            IR_ADC_Value   <= (ir_avg >= dark_avg) ? ir_avg - dark_avg : 8'd0;
                            sample_valid   <= 1'b1;
                            red_acc        <= '0;
                            ir_acc         <= '0;
                            dark_acc       <= '0;
                        end
                        default: ;
                    endcase
                end else begin
                    phase_cnt <= phase_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_phase_sampler.sv
// Directed bench for adc_phase_sampler: frame-by-frame stimulus with a queue of expected
// published values, checked against the strobe; also covers abort and async reset.
module tb_adc_phase_sampler;
    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] ADC = 8'd0;
    logic       LED_RED, LED_IR, sample_valid;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;

    adc_phase_sampler #(
        .PHASE_CYCLES (10),
        .SETTLE_CYCLES(4),
        .AVG_LOG2     (2)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .enable        (enable),
        .ADC           (ADC),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .DARK_ADC_Value(DARK_ADC_Value),
        .sample_valid  (sample_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] r;
        logic [7:0] i;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued frame expectation.
    always @(negedge CLK) begin
        if (!rst && sample_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("red_value", RED_ADC_Value, e.r);
                check("ir_value", IR_ADC_Value, e.i);
                check("dark_value", DARK_ADC_Value, e.d);
            end
        end
    end

    function automatic logic [7:0] avg4(input logic [3:0][7:0] w);
        int s;
        s = int'(w[0]) + int'(w[1]) + int'(w[2]) + int'(w[3]);
        return 8'(s / 4);
    endfunction

    // Entered #1 after the edge that starts RED (cycle k = 0); drives `cycles` cycles of ADC.
    task automatic frame(input logic [3:0][7:0] rw, input logic [3:0][7:0] iw,
                         input logic [3:0][7:0] dw, input logic [7:0] fill, input int cycles);
        exp_t e;
        logic [7:0] ra, ia, da;
        ra = avg4(rw);
        ia = avg4(iw);
        da = avg4(dw);
        e.d = da;
        e.r = (ra >= da) ? ra - da : 8'd0;
        e.i = (ia >= da) ? ia - da : 8'd0;
        if (cycles == 30) sb.push_back(e);
        for (int k = 0; k < cycles; k++) begin
            int ph, c;
            ph = k / 10;
            c  = k % 10;
            check("led_red", LED_RED, (ph == 0) ? 8'd1 : 8'd0);
            check("led_ir", LED_IR, (ph == 1) ? 8'd1 : 8'd0);
            if (k > 0) check("valid_low_in_frame", sample_valid, 8'd0);
            if (c >= 4 && c <= 7) begin
                case (ph)
                    0:       ADC = rw[c-4];
                    1:       ADC = iw[c-4];
                    default: ADC = dw[c-4];
                endcase
            end else begin
                ADC = fill;
            end
            @(posedge CLK);
            #1;
        end
        if (cycles == 30) check("valid_at_frame_end", sample_valid, 8'd1);
    endtask

    localparam logic [3:0][7:0] W200 = {4{8'd200}};
    localparam logic [3:0][7:0] W120 = {4{8'd120}};
    localparam logic [3:0][7:0] W20  = {4{8'd20}};
    localparam logic [3:0][7:0] W100 = {4{8'd100}};
    localparam logic [3:0][7:0] W30  = {4{8'd30}};
    localparam logic [3:0][7:0] W90  = {4{8'd90}};
    localparam logic [3:0][7:0] W50  = {4{8'd50}};
    localparam logic [3:0][7:0] W0   = {4{8'd0}};
    localparam logic [3:0][7:0] WTRN = {8'd11, 8'd11, 8'd11, 8'd10};

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_led_red", LED_RED, 8'd0);
        check("rst_led_ir", LED_IR, 8'd0);
        check("rst_valid", sample_valid, 8'd0);
        check("rst_red", RED_ADC_Value, 8'd0);
        check("rst_ir", IR_ADC_Value, 8'd0);
        check("rst_dark", DARK_ADC_Value, 8'd0);
        rst = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_led_red", LED_RED, 8'd0);
        enable = 1'b1;
        @(posedge CLK);
        #1;

        // Basic frame twice (strobe period 30), settle exclusion, ambient floor, truncation
        frame(W200, W120, W20, 8'd200, 30);
        frame(W200, W120, W20, 8'd120, 30);
        frame(W100, W100, W100, 8'd255, 30);
        frame(W30, W90, W50, 8'd0, 30);
        frame(WTRN, W0, W0, 8'd200, 30);
        frame(W200, W120, W20, 8'd20, 30);

        // Abort at IR phase_cnt 5
        frame(W200, W120, W20, 8'd20, 15);
        check("abort_led_ir_before", LED_IR, 8'd1);
        enable = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_led_ir", LED_IR, 8'd0);
        check("abort_led_red", LED_RED, 8'd0);
        check("abort_red_hold", RED_ADC_Value, 8'd180);
        check("abort_ir_hold", IR_ADC_Value, 8'd100);
        check("abort_dark_hold", DARK_ADC_Value, 8'd20);
        for (int k = 0; k < 35; k++) begin
            check("abort_no_valid", sample_valid, 8'd0);
            @(posedge CLK);
            #1;
        end
        enable = 1'b1;
        @(posedge CLK);
        #1;
        frame(W200, W120, W20, 8'd0, 30);

        // Async reset mid-DARK
        frame(W30, W90, W50, 8'd0, 25);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led_red", LED_RED, 8'd0);
        check("arst_led_ir", LED_IR, 8'd0);
        check("arst_valid", sample_valid, 8'd0);
        check("arst_red", RED_ADC_Value, 8'd0);
        check("arst_ir", IR_ADC_Value, 8'd0);
        check("arst_dark", DARK_ADC_Value, 8'd0);
        @(posedge CLK);
        #3;
        rst = 1'b0;
        @(posedge CLK);
        #1;
        frame(W200, W120, W20, 8'd50, 30);
        repeat (2) @(posedge CLK);
        #1;
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
